// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// instruction field bit positions and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int JA_MSB  = 25;
    localparam int JA_LSB  = 0;

endpackage

// File: rtl/instr_field_decoder.sv
// Pure combinational slicing of a registered instruction word into its
// MIPS-style fields.
module instr_field_decoder
    import fetch_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  opcode_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm16_o,
    output logic [25:0] jaddr_o
);

    assign opcode_o = instr_i[OPC_MSB:OPC_LSB];
    assign rs_o     = instr_i[RS_MSB:RS_LSB];
    assign rt_o     = instr_i[RT_MSB:RT_LSB];
    assign rd_o     = instr_i[RD_MSB:RD_LSB];
    assign shamt_o  = instr_i[SH_MSB:SH_LSB];
    assign funct_o  = instr_i[FN_MSB:FN_LSB];
    assign imm16_o  = instr_i[IMM_MSB:IMM_LSB];
    assign jaddr_o  = instr_i[JA_MSB:JA_LSB];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/FETCH/HOLD handshake FSM with imem,
// redirect handling and a registered instruction with decoded fields.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        fetch_err
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_out_q;
    logic         valid_q;
    logic         err_q;

    // Request is combinational so reset and redirect kill it in the same cycle.
    assign imem_req  = (state_q == ST_FETCH) && !stall && !redirect && !reset;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (redirect) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
            if (redirect_pc[1:0] != 2'b00)
                err_q <= 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (stall) begin
                        state_q <= ST_HOLD;
                    end else if (imem_ready) begin
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + 32'd4;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Release cycle is the one where the consumer takes the held
                    // word, so drop valid to avoid presenting it twice.
                    if (!stall) begin
                        state_q <= ST_FETCH;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign fetch_err   = err_q;

    instr_field_decoder u_dec (
        .instr_i  (instr_q),
        .opcode_o (opcode),
        .rs_o     (rs),
        .rt_o     (rt),
        .rd_o     (rd),
        .shamt_o  (shamt),
        .funct_o  (funct),
        .imm16_o  (imm16),
        .jaddr_o  (jaddr)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a scoreboard of fetched words.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, stall, redirect, instr_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc_out, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    // second instance exercising the PC wrap from the top of memory
    logic        imem_req2, instr_valid2, fetch_err2;
    logic [31:0] imem_addr2, instr2, pc_out2, pc_plus4_2;
    logic [5:0]  opcode2, funct2;
    logic [4:0]  rs2, rt2, rd2, shamt2;
    logic [15:0] imm16_2;
    logic [25:0] jaddr2;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
        .jaddr(jaddr), .fetch_err(fetch_err)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(1'b1), .imem_rdata(32'h1234_5678), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0), .instr_valid(instr_valid2),
        .instr(instr2), .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .opcode(opcode2),
        .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2), .funct(funct2), .imm16(imm16_2),
        .jaddr(jaddr2), .fetch_err(fetch_err2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] mpc, last_word, last_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        exp_t e;
        chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instr",    instr,            e.word);
            chk("pc_out",   pc_out,           e.pc);
            chk("pc_plus4", pc_plus4,         e.pc + 32'd4);
            chk("opcode",   {26'd0, opcode},  {26'd0, e.word[31:26]});
            chk("rs",       {27'd0, rs},      {27'd0, e.word[25:21]});
            chk("rt",       {27'd0, rt},      {27'd0, e.word[20:16]});
            chk("rd",       {27'd0, rd},      {27'd0, e.word[15:11]});
            chk("shamt",    {27'd0, shamt},   {27'd0, e.word[10:6]});
            chk("funct",    {26'd0, funct},   {26'd0, e.word[5:0]});
            chk("imm16",    {16'd0, imm16},   {16'd0, e.word[15:0]});
            chk("jaddr",    {6'd0, jaddr},    {6'd0, e.word[25:0]});
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic fetch_ok(input logic [31:0] w);
        stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; imem_rdata = w;
        #1;
        chk("fetch_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, mpc);
        sb.push_back({mpc, w});
        tick();
        chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
        pop_check();
        last_word = w; last_pc = mpc; mpc = mpc + 32'd4;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        mpc = 32'h0; last_word = '0; last_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_pcout", pc_out,               32'd0);
        chk("rst_err",   {31'd0, fetch_err},   32'd0);

        // cycle 1 after release: BOOT, no request
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_FFC0;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        // cycle 2: first fetch at RESET_PC on both instances
        chk("wrap_req",  {31'd0, imem_req2}, 32'd1);
        chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        fetch_ok(32'h2008_FFC0);
        chk("first_opcode", {26'd0, opcode}, 32'h08);
        chk("first_rt",     {27'd0, rt},     32'd8);
        chk("first_imm",    {16'd0, imm16},  32'hFFC0);
        chk("first_pc4",    pc_plus4,        32'd4);
        chk("wrap_pcout",   pc_out2,         32'hFFFF_FFFC);
        chk("wrap_next",    imem_addr2,      32'h0000_0000);

        fetch_ok(32'h0123_4567);
        fetch_ok(32'h8C41_0010);

        // stall for 3 cycles while an instruction is valid
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
            #1;
            chk("stall_req",  {31'd0, imem_req}, 32'd0);
            chk("stall_addr", imem_addr, mpc);
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr,  last_word);
            chk("stall_pcout", pc_out, last_pc);
            @(negedge clk);
        end
        stall = 1'b0; imem_ready = 1'b1;
        #1;
        chk("release_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("release_valid", {31'd0, instr_valid}, 32'd0);
        chk("release_instr", instr, last_word);
        @(negedge clk);
        fetch_ok(32'h0000_0020);

        // aligned redirect coincident with a returned word
        redirect = 1'b1; redirect_pc = 32'h0000_0100; imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_drop",  instr, last_word);
        chk("redir_err",   {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        redirect = 1'b0; mpc = 32'h0000_0100;
        fetch_ok(32'h3C01_1234);

        // misaligned redirect sets the sticky error
        redirect = 1'b1; redirect_pc = 32'h0000_0102; imem_ready = 1'b0;
        tick();
        chk("misalign_err", {31'd0, fetch_err}, 32'd1);
        @(negedge clk);
        redirect = 1'b0; mpc = 32'h0000_0100;
        fetch_ok(32'h0800_0040);

        // memory not ready for 4 cycles
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
            #1;
            chk("wait_req",  {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, mpc);
            tick();
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        fetch_ok(32'h0000_0008);
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);

        // reset in the middle of an outstanding request
        imem_ready = 1'b0;
        #1;
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req",   {31'd0, imem_req},    32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_err",   {31'd0, fetch_err},   32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0; mpc = 32'h0;
        #1;
        chk("reboot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        fetch_ok(32'hAC22_0004);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, word-aligned address fetched first after reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  imem_req  out  1  fetch request to instruction memory
  imem_addr  out  32  fetch address (current PC)
  imem_ready  in  1  imem_rdata valid this cycle for imem_addr
  imem_rdata  in  32  fetched instruction word
  stall  in  1  downstream cannot accept current instruction
  redirect  in  1  branch/jump taken; refetch from redirect_pc
  redirect_pc  in  32  new fetch target
  instr_valid  out  1  instr and fields hold a valid instruction
  instr  out  32  registered instruction word
  pc_out  out  32  address of instr
  pc_plus4  out  32  pc_out + 4
  opcode  out  6  instr[31:26]
  rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
  shamt  out  5  instr[10:6]
  funct  out  6  instr[5:0]
  imm16  out  16  instr[15:0], the raw immediate fed to the sign-extension stage
  jaddr  out  26  instr[25:0]
  fetch_err  out  1  sticky flag: misaligned redirect received

Function
REQ-004 SHALL implement FSM states BOOT, FETCH, HOLD.
REQ-005 BOOT: imem_req=0; the state SHALL always advance to FETCH on the next clock.
REQ-006 FETCH: imem_req = !stall; imem_addr = PC at all times.
REQ-007 FETCH with stall=1: no request; state SHALL go to HOLD; outputs held.
REQ-008 FETCH with imem_req=1 and imem_ready=1: instr<=imem_rdata, pc_out<=PC, instr_valid<=1, PC<=PC+4; state SHALL stay FETCH.
REQ-009 FETCH with imem_req=1 and imem_ready=0: PC SHALL be held; instr_valid<=0 (the previous instruction is consumed because stall=0).
REQ-010 HOLD: imem_req=0; all outputs held; stall=0 SHALL cause a transition to FETCH.
REQ-011 Latency: a word accepted with imem_ready in cycle N SHALL appear on instr and all fields in cycle N+1.
REQ-012 Fields, pc_plus4 SHALL be pure combinational slices/sum of the registered instr/pc_out.
REQ-013 The consumer SHALL take an instruction only in a cycle with instr_valid=1 and stall=0; each fetched word SHALL be presented exactly once.
REQ-014 redirect=1 in any state SHALL take priority over imem_ready and stall: PC<=redirect_pc with bits [1:0] cleared, instr_valid<=0, and imem_rdata returned that cycle is discarded; next state is FETCH.
REQ-015 redirect with redirect_pc[1:0]!=0 SHALL set fetch_err, which stays set until reset.
REQ-016 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-017 imem_req SHALL never be asserted in BOOT, HOLD, or in a redirect cycle.

Reset
REQ-018 On reset: state=BOOT, PC=RESET_PC, instr=0, pc_out=0, instr_valid=0, fetch_err=0; imem_req=0 immediately (asynchronously).
REQ-019 Reset asserted mid-fetch SHALL abandon the request; the first request after release SHALL be to RESET_PC.

Structure
REQ-020 Shared package fetch_pkg SHALL hold the state-type enumeration, the instruction field bit positions, and the default RESET_PC constant.
REQ-021 Field slicing SHALL be one sub-module, instr_field_decoder (combinational); PC, FSM and handshake SHALL be in instruction_fetch.

Verification
REQ-022 Reset release, imem_ready=1 constant, rdata=32'h2008_FFC0 -> first imem_addr=0 in cycle 2; next cycle opcode=6'h08, rt=8, imm16=16'hFFC0, pc_out=0, pc_plus4=4.
REQ-023 Stall=1 for 3 cycles while instr_valid -> imem_req=0, instr unchanged, PC unchanged; on release exactly one new fetch at next PC.
REQ-024 redirect=1, redirect_pc=32'h0000_0100 coincident with imem_ready=1 -> returned word dropped, instr_valid=0 next cycle, next imem_addr=32'h100.
REQ-025 redirect_pc=32'h0000_0102 -> fetch_err=1, next imem_addr=32'h100; fetch_err remains 1 until reset.
REQ-026 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_out=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-027 imem_ready=0 for 4 cycles then 1 -> imem_addr held at the same PC, instr_valid=0 throughout, valid asserted one cycle after ready.
